// File: rtl/dpram_clr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpram_clr_pkg
// Description : Shared types and helpers for the self-clearing dual-port RAM.
//               - state_e    : controller states (ST_CLEAR, ST_READY)
//               - num_lanes  : number of byte lanes in a word
//               - byte_merge : per-byte select between an old and a new word
//               byte_merge works on a fixed maximum width; callers extend
//               their operands to MAX_DW bits and truncate the result.
// Revision    : 1.0 - initial release
// ============================================================================
package dpram_clr_pkg;

  localparam int unsigned MAX_DW    = 1024;
  localparam int unsigned MAX_LANES = MAX_DW / 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int unsigned num_lanes(input int unsigned dw);
    return dw / 8;
  endfunction

  // Lanes with be set come from new_w, all other lanes keep old_w.
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0]    old_w,
    input logic [MAX_DW-1:0]    new_w,
    input logic [MAX_LANES-1:0] be
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_clr_core.sv
`default_nettype none
// ============================================================================
// Module      : dpram_clr_core
// Description : Storage array with one byte-enabled write port and one
//               registered read port. A read and a write to the same word in
//               the same cycle return the old content.
// Ports       : clk_i    - clock
//               rst_i    - synchronous active-high reset (read register only)
//               we_i     - write enable
//               waddr_i  - write word index (must be < NUMWORDS)
//               be_i     - byte lane enables for the write
//               wdata_i  - write data
//               re_i     - read enable; read register holds when low
//               raddr_i  - read word index (must be < NUMWORDS when re_i)
//               rdata_o  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_clr_core
  import dpram_clr_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int NUMWORDS  = 1024,
  parameter int AW        = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [DATAWIDTH/8-1:0] be_i,
  input  logic [DATAWIDTH-1:0]   wdata_i,
  input  logic                   re_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [DATAWIDTH-1:0]   rdata_o
);

  logic [DATAWIDTH-1:0] mem_q [NUMWORDS];
  logic [DATAWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= DATAWIDTH'(byte_merge(MAX_DW'(mem_q[waddr_i]),
                                              MAX_DW'(wdata_i),
                                              MAX_LANES'(be_i)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dpram_clr.sv
`default_nettype none
// ============================================================================
// Module      : dpram_clr
// Description : Single-clock dual-port RAM with per-byte write enables,
//               automatic clear to CLEAR_VALUE after every reset, a read-valid
//               pipeline and an optional output register (OUTREG=1).
//               Optional feature macro DPRAM_CLR_BYPASS_EN: a same-cycle write
//               and read to the same in-range address return the new data,
//               merged per byte with the old content.
// Ports       : clock     - sole clock
//               reset     - synchronous active-high reset, restarts the clear
//               wraddress - write address
//               wren      - write strobe
//               byteena   - write byte lane enables
//               data      - write data
//               rdaddress - read address
//               rden      - read request
//               q         - read data, holds while q_valid is low
//               q_valid   - q carries data for an accepted request
//               busy      - clear in progress, user accesses ignored
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_clr
  import dpram_clr_pkg::*;
#(
  parameter int                   DATAWIDTH   = 16,
  parameter int                   ADDRWIDTH   = 10,
  parameter int                   NUMWORDS    = 1 << ADDRWIDTH,
  parameter logic [DATAWIDTH-1:0] CLEAR_VALUE = '0,
  parameter int                   OUTREG      = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDRWIDTH-1:0]   wraddress,
  input  logic                   wren,
  input  logic [DATAWIDTH/8-1:0] byteena,
  input  logic [DATAWIDTH-1:0]   data,
  input  logic [ADDRWIDTH-1:0]   rdaddress,
  input  logic                   rden,
  output logic [DATAWIDTH-1:0]   q,
  output logic                   q_valid,
  output logic                   busy
);

  localparam int                   LANES     = num_lanes(DATAWIDTH);
  localparam int                   IDXW      = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUMWORDS - 1);
  localparam logic [ADDRWIDTH:0]   DEPTH     = (ADDRWIDTH+1)'(NUMWORDS);

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
  logic                 clr_we;

  logic                 wr_in_range, rd_in_range;
  logic                 wr_user, rd_acc;

  logic                 core_we;
  logic [ADDRWIDTH-1:0] core_waddr;
  logic [LANES-1:0]     core_be;
  logic [DATAWIDTH-1:0] core_wdata, core_rdata;

  logic                 v1_q, oor1_q;
  logic [DATAWIDTH-1:0] ram_word, s1_data;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + ADDRWIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  // ---------------------------------------------------------- write / read
  assign wr_in_range = ({1'b0, wraddress} < DEPTH);
  assign rd_in_range = ({1'b0, rdaddress} < DEPTH);

  assign wr_user = wren & (state_q == ST_READY) & wr_in_range;
  assign rd_acc  = rden & (state_q == ST_READY);

  // Clear and user writes are mutually exclusive by state; the clear owns
  // the write port while busy.
  assign core_we    = ~reset & (clr_we | wr_user);
  assign core_waddr = clr_we ? cnt_q         : wraddress;
  assign core_be    = clr_we ? {LANES{1'b1}} : byteena;
  assign core_wdata = clr_we ? CLEAR_VALUE   : data;

  dpram_clr_core #(
    .DATAWIDTH (DATAWIDTH),
    .NUMWORDS  (NUMWORDS),
    .AW        (IDXW)
  ) u_core (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (core_we),
    .waddr_i (core_waddr[IDXW-1:0]),
    .be_i    (core_be),
    .wdata_i (core_wdata),
    .re_i    (rd_acc & rd_in_range),
    .raddr_i (rdaddress[IDXW-1:0]),
    .rdata_o (core_rdata)
  );

  // First read stage: valid bit plus out-of-range flag. The flag only
  // updates on accepted reads so q holds between requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q   <= 1'b0;
      oor1_q <= 1'b0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        oor1_q <= ~rd_in_range;
      end
    end
  end

`ifdef DPRAM_CLR_BYPASS_EN
  logic                 byp_hit_q;
  logic [DATAWIDTH-1:0] byp_data_q;
  logic [LANES-1:0]     byp_be_q;

  // Capture the colliding write; the core returns old content, so the
  // enabled lanes are patched in after the read register.
  always_ff @(posedge clock) begin
    if (reset) begin
      byp_hit_q <= 1'b0;
    end else if (rd_acc) begin
      byp_hit_q <= wr_user & (wraddress == rdaddress);
    end
  end

  always_ff @(posedge clock) begin
    if (rd_acc) begin
      byp_data_q <= data;
      byp_be_q   <= byteena;
    end
  end

  assign ram_word = byp_hit_q
                  ? DATAWIDTH'(byte_merge(MAX_DW'(core_rdata),
                                          MAX_DW'(byp_data_q),
                                          MAX_LANES'(byp_be_q)))
                  : core_rdata;
`else
  assign ram_word = core_rdata;
`endif

  assign s1_data = oor1_q ? CLEAR_VALUE : ram_word;

  // ------------------------------------------------------------ output stage
  generate
    if (OUTREG != 0) begin : g_outreg
      logic [DATAWIDTH-1:0] q_q;
      logic                 v2_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          q_q  <= '0;
          v2_q <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) begin
            q_q <= s1_data;
          end
        end
      end

      assign q       = q_q;
      assign q_valid = v2_q;
    end else begin : g_direct
      assign q       = s1_data;
      assign q_valid = v1_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dpram_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_clr
// Description : Testbench for dpram_clr. Three instances share one stimulus:
//               A: 8 words, OUTREG=0; B: 8 words, OUTREG=1; C: 6 words,
//               OUTREG=0. All use DATAWIDTH=16, CLEAR_VALUE=16'hA5A5.
//               Expectations for same-address collisions follow the
//               DPRAM_CLR_BYPASS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_clr;

  localparam logic [15:0] CV = 16'hA5A5;
`ifdef DPRAM_CLR_BYPASS_EN
  localparam logic [15:0] E_COL_FULL = 16'h5678;
  localparam logic [15:0] E_COL_HI   = 16'h56A5;
`else
  localparam logic [15:0] E_COL_FULL = 16'hA5A5;
  localparam logic [15:0] E_COL_HI   = 16'hA5A5;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  wraddress, rdaddress;
  logic        wren, rden;
  logic [1:0]  byteena;
  logic [15:0] data;
  logic [15:0] q_a, q_b, q_c;
  logic        v_a, v_b, v_c;
  logic        busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dpram_clr #(.DATAWIDTH(16), .ADDRWIDTH(3), .NUMWORDS(8), .CLEAR_VALUE(CV), .OUTREG(0)) u_a (
    .clock(clk), .reset(reset), .wraddress(wraddress), .wren(wren), .byteena(byteena),
    .data(data), .rdaddress(rdaddress), .rden(rden), .q(q_a), .q_valid(v_a), .busy(busy_a));

  dpram_clr #(.DATAWIDTH(16), .ADDRWIDTH(3), .NUMWORDS(8), .CLEAR_VALUE(CV), .OUTREG(1)) u_b (
    .clock(clk), .reset(reset), .wraddress(wraddress), .wren(wren), .byteena(byteena),
    .data(data), .rdaddress(rdaddress), .rden(rden), .q(q_b), .q_valid(v_b), .busy(busy_b));

  dpram_clr #(.DATAWIDTH(16), .ADDRWIDTH(3), .NUMWORDS(6), .CLEAR_VALUE(CV), .OUTREG(0)) u_c (
    .clock(clk), .reset(reset), .wraddress(wraddress), .wren(wren), .byteena(byteena),
    .data(data), .rdaddress(rdaddress), .rden(rden), .q(q_c), .q_valid(v_c), .busy(busy_c));

  typedef struct {
    logic        wren;
    logic [2:0]  wa;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        rden;
    logic [2:0]  ra;
    logic        exp_v;
    logic [15:0] exp_qa;
    logic [15:0] exp_qc;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic w, input logic [2:0] wa, input logic [1:0] be,
                              input logic [15:0] wd, input logic r, input logic [2:0] ra,
                              input logic ev, input logic [15:0] qa, input logic [15:0] qc);
    vec_t v;
    v.wren = w;  v.wa = wa; v.be = be; v.wd = wd;
    v.rden = r;  v.ra = ra;
    v.exp_v = ev; v.exp_qa = qa; v.exp_qc = qc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren = 1'b0; rden = 1'b0; wraddress = '0; rdaddress = '0; byteena = '0; data = '0;
  endtask

  // Counts samples with busy high on A (and C while A is busy); any
  // q_valid on A during that time is an error.
  task automatic count_busy(output int na, output int nc, output int bad);
    na = 0; nc = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (v_a) bad++;
      if (busy_c) nc++;
      if (!busy_a) break;
      na++;
      cyc();
    end
  endtask

  initial begin
    int na, nc, bad;
    logic pv;
    logic [15:0] pq;
    logic [2:0] ad [3];
    logic [15:0] seq_q [6];
    logic seq_v [6];

    // ---------------------------------------------------- vector table
    for (int i = 0; i < 8; i++) vecs[i] = mk(0, 0, 0, 0, 1, 3'(i), 1, CV, CV);
    vecs[8]  = mk(1, 3, 2'b01, 16'h1234, 0, 0, 0, CV,         CV);
    vecs[9]  = mk(0, 0, 2'b00, 16'h0000, 1, 3, 1, 16'hA534,   16'hA534);
    vecs[10] = mk(1, 3, 2'b10, 16'hBEEF, 0, 0, 0, 16'hA534,   16'hA534);
    vecs[11] = mk(0, 0, 2'b00, 16'h0000, 1, 3, 1, 16'hBE34,   16'hBE34);
    vecs[12] = mk(1, 5, 2'b11, 16'h5678, 1, 5, 1, E_COL_FULL, E_COL_FULL);
    vecs[13] = mk(0, 0, 2'b00, 16'h0000, 1, 5, 1, 16'h5678,   16'h5678);
    vecs[14] = mk(1, 6, 2'b10, 16'h5678, 1, 6, 1, E_COL_HI,   CV);
    vecs[15] = mk(0, 0, 2'b00, 16'h0000, 1, 6, 1, 16'h56A5,   CV);
    vecs[16] = mk(1, 7, 2'b11, 16'hFFFF, 0, 0, 0, 16'h56A5,   CV);
    vecs[17] = mk(0, 0, 2'b00, 16'h0000, 1, 7, 1, 16'hFFFF,   CV);
    vecs[18] = mk(1, 0, 2'b00, 16'h1111, 1, 0, 1, CV,         CV);
    vecs[19] = mk(0, 0, 2'b00, 16'h0000, 1, 0, 1, CV,         CV);
    vecs[20] = mk(0, 0, 2'b00, 16'h0000, 0, 0, 0, CV,         CV);
    vecs[21] = mk(1, 1, 2'b11, 16'hCAFE, 0, 0, 0, CV,         CV);
    vecs[22] = mk(0, 0, 2'b00, 16'h0000, 1, 1, 1, 16'hCAFE,   16'hCAFE);

    // ---------------------------------------------------- reset state
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    check("reset q_a", 32'(q_a), 32'h0);
    check("reset v_a", 32'(v_a), 32'h0);
    check("reset busy_a", 32'(busy_a), 32'h1);
    check("reset q_b", 32'(q_b), 32'h0);
    check("reset v_b", 32'(v_b), 32'h0);
    check("reset busy_b", 32'(busy_b), 32'h1);
    check("reset busy_c", 32'(busy_c), 32'h1);

    // ------------------------- clear length, accesses ignored while busy
    wren = 1'b1; wraddress = 3'd7; byteena = 2'b11; data = 16'hFFFF;
    rden = 1'b1; rdaddress = 3'd7;
    reset = 1'b0;
    count_busy(na, nc, bad);
    idle();
    check("clear cycles A", 32'(na), 32'd8);
    check("clear cycles C", 32'(nc), 32'd6);
    check("q_valid during busy", 32'(bad), 32'd0);

    // ---------------------------------------------------- table run
    pv = 1'b0;
    pq = '0;
    for (int k = 0; k < NV; k++) begin
      wren = vecs[k].wren; wraddress = vecs[k].wa; byteena = vecs[k].be; data = vecs[k].wd;
      rden = vecs[k].rden; rdaddress = vecs[k].ra;
      cyc();
      check($sformatf("row%0d v_a", k), 32'(v_a), 32'(vecs[k].exp_v));
      check($sformatf("row%0d q_a", k), 32'(q_a), 32'(vecs[k].exp_qa));
      check($sformatf("row%0d v_c", k), 32'(v_c), 32'(vecs[k].exp_v));
      check($sformatf("row%0d q_c", k), 32'(q_c), 32'(vecs[k].exp_qc));
      check($sformatf("row%0d v_b", k), 32'(v_b), 32'(pv));
      if (pv) check($sformatf("row%0d q_b", k), 32'(q_b), 32'(pq));
      pv = vecs[k].exp_v;
      pq = vecs[k].exp_qa;
    end

    // --------------------------- OUTREG=1 back-to-back reads 0..3
    idle();
    cyc();
    check("B tail v_b", 32'(v_b), 32'h1);
    check("B tail q_b", 32'(q_b), 32'hCAFE);
    cyc();
    seq_v = '{0, 1, 1, 1, 1, 0};
    seq_q = '{16'h0, CV, 16'hCAFE, CV, 16'hBE34, 16'h0};
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        rden = 1'b1; rdaddress = 3'(j);
      end else begin
        idle();
      end
      cyc();
      check($sformatf("burst%0d v_b", j), 32'(v_b), 32'(seq_v[j]));
      if (seq_v[j]) check($sformatf("burst%0d q_b", j), 32'(q_b), 32'(seq_q[j]));
    end

    // --------------------------- reset with a read in flight
    rden = 1'b1; rdaddress = 3'd3;
    cyc();
    check("pre-reset v_a", 32'(v_a), 32'h1);
    check("pre-reset q_a", 32'(q_a), 32'hBE34);
    rden = 1'b0;
    reset = 1'b1;
    cyc();
    check("inflight v_b", 32'(v_b), 32'h0);
    check("inflight q_b", 32'(q_b), 32'h0);
    check("inflight q_a", 32'(q_a), 32'h0);
    check("inflight busy_a", 32'(busy_a), 32'h1);

    // --------------------------- reset again at clear cycle 4
    reset = 1'b0;
    repeat (4) cyc();
    check("mid-clear busy_a", 32'(busy_a), 32'h1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wren = 1'b1; wraddress = 3'd1; byteena = 2'b11; data = 16'h0000;
    rden = 1'b1; rdaddress = 3'd1;
    count_busy(na, nc, bad);
    idle();
    check("restart clear cycles A", 32'(na), 32'd8);
    check("restart clear cycles C", 32'(nc), 32'd6);
    check("restart q_valid during busy", 32'(bad), 32'd0);

    ad = '{3'd1, 3'd3, 3'd7};
    for (int j = 0; j < 3; j++) begin
      rden = 1'b1; rdaddress = ad[j];
      cyc();
      check($sformatf("recleared v_a addr%0d", ad[j]), 32'(v_a), 32'h1);
      check($sformatf("recleared q_a addr%0d", ad[j]), 32'(q_a), 32'(CV));
    end
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
